move_scheduler: RTL

Front-end controller for the maze player datapath. It takes raw push-button levels and applies synchronisation, debouncing and edge detection. It then issues at most one single-cycle one-hot move/turn command to the player block per render frame. It holds off further commands until the renderer reports the frame is redrawn, then applies a cooldown, so every step is drawn before the next one is applied.

---
 rtl/wayout_pkg.sv | 37 +++
 rtl/move_scheduler_btn_debounce.sv | 52 +++++
 rtl/move_scheduler.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/wayout_pkg.sv
// Shared types and key-index constants for the maze player front end.
// Includes the fixed-priority one-hot selector used when issuing commands.
package wayout_pkg;

  localparam int KEY_BACK   = 0;
  localparam int KEY_FWD    = 1;
  localparam int KEY_TURN_R = 2;
  localparam int KEY_TURN_L = 3;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    ISSUE       = 2'd1,
    WAIT_RENDER = 2'd2,
    COOLDOWN    = 2'd3
  } sched_state_t;

  typedef logic [3:0] key_vec_t;

  // Turns win over moves so a turn-then-step pair always draws the turn first.
  function automatic key_vec_t prio_onehot(input key_vec_t pend);
    key_vec_t sel;
    sel = 4'b0000;
    if (pend[KEY_TURN_L]) begin
      sel[KEY_TURN_L] = 1'b1;
    end else if (pend[KEY_TURN_R]) begin
      sel[KEY_TURN_R] = 1'b1;
    end else if (pend[KEY_FWD]) begin
      sel[KEY_FWD] = 1'b1;
    end else if (pend[KEY_BACK]) begin
      sel[KEY_BACK] = 1'b1;
    end else begin
      sel = 4'b0000;
    end
    return sel;
  endfunction

endpackage

// File: rtl/move_scheduler_btn_debounce.sv
// One push-button lane: 2-flop synchroniser, stable-count debouncer and
// a one-cycle pulse on each debounced 0->1 transition.
module btn_debounce
  import wayout_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 250000
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_btn,
  output logic o_level,
  output logic o_rise
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_level_d;

  // Synchronise, then accept a new level only after it has differed for DEBOUNCE_CYC samples.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
    end else begin
      r_sync1   <= i_btn;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      if (r_sync2 != r_level) begin
        if (r_cnt == CNT_LAST) begin
          r_level <= r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_level & ~r_level_d;

endmodule

// File: rtl/move_scheduler.sv
// Button front end for the maze player: one one-hot command per rendered frame,
// gated by render_done and a cooldown. Optional auto-repeat: MOVE_SCHEDULER_REPEAT_EN.
module move_scheduler
  import wayout_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 250000,
  parameter int COOLDOWN_CYC = 50000,
  parameter int TIMEOUT_CYC  = 5000000,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_CYC   = 12500000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [3:0] btn_raw,
  input  logic       render_done,
  output logic [3:0] key_pressed,
  output logic       refresh_req,
  output logic       busy,
  output logic       timeout_err
);

  localparam int TW  = $clog2(TIMEOUT_CYC + 1);
  localparam int CDW = (COOLDOWN_CYC > 0) ? $clog2(COOLDOWN_CYC + 1) : 1;
  // The error pulse is registered, so the decision is taken one count early.
  localparam logic [TW-1:0]  WAIT_LAST = TW'(TIMEOUT_CYC - 2);
  localparam logic [CDW-1:0] COOL_LAST = CDW'((COOLDOWN_CYC > 0) ? COOLDOWN_CYC - 1 : 0);

  if (DEBOUNCE_CYC < 1 || TIMEOUT_CYC < 2 || COOLDOWN_CYC < 0 ||
      REPEAT_DELAY < 1 || REPEAT_CYC < 1) begin : g_cfg_err
    $error("move_scheduler: invalid parameter configuration");
  end

  logic         r_rst_meta;
  logic         r_rst_sync;
  logic         w_rst_n;
  key_vec_t     w_level;
  key_vec_t     w_rise;
  key_vec_t     w_rep_set;
  key_vec_t     w_pend_nxt;
  key_vec_t     r_pending;
  sched_state_t r_state;
  sched_state_t w_state_nxt;
  logic         w_timeout;
  logic [TW-1:0]  r_wait_cnt;
  logic [CDW-1:0] r_cool_cnt;
  key_vec_t     r_key_pressed;
  logic         r_refresh_req;
  logic         r_busy;
  logic         r_timeout_err;
  logic         w_unused_level;

  // Reset asserts immediately and releases two clocks after rstn rises.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rst_meta <= 1'b0;
      r_rst_sync <= 1'b0;
    end else begin
      r_rst_meta <= 1'b1;
      r_rst_sync <= r_rst_meta;
    end
  end
  assign w_rst_n = r_rst_sync;

  for (genvar g = 0; g < 4; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_btn_debounce (
      .clk    (clk),
      .rstn   (w_rst_n),
      .i_btn  (btn_raw[g]),
      .o_level(w_level[g]),
      .o_rise (w_rise[g])
    );
  end

  // Turn levels only matter through their edges.
  assign w_unused_level = ^w_level;

`ifdef MOVE_SCHEDULER_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_CYC) ? REPEAT_DELAY : REPEAT_CYC;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RC_LAST = RW'(REPEAT_CYC - 1);

  logic [RW-1:0] r_rep_cnt [2];
  logic [1:0]    r_rep_first;

  // Hold-time counters for the two move buttons; release restarts the initial delay.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_rep_cnt[0] <= '0;
      r_rep_cnt[1] <= '0;
      r_rep_first  <= 2'b11;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!w_level[i]) begin
          r_rep_cnt[i]   <= '0;
          r_rep_first[i] <= 1'b1;
        end else if (w_rep_set[i]) begin
          r_rep_cnt[i]   <= '0;
          r_rep_first[i] <= 1'b0;
        end else begin
          r_rep_cnt[i] <= r_rep_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Repeat request fires on the last cycle of the current hold interval.
  always_comb begin
    w_rep_set = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      if (w_level[i] && (r_rep_cnt[i] == (r_rep_first[i] ? RD_LAST : RC_LAST))) begin
        w_rep_set[i] = 1'b1;
      end else begin
        w_rep_set[i] = 1'b0;
      end
    end
  end
`else
  assign w_rep_set = 4'b0000;
`endif

  // Issued bit clears after ISSUE; a set in the same cycle overrides the clear.
  always_comb begin
    w_pend_nxt = r_pending;
    if (r_state == ISSUE) begin
      w_pend_nxt = r_pending & ~r_key_pressed;
    end else begin
      w_pend_nxt = r_pending;
    end
    w_pend_nxt = w_pend_nxt | w_rise | w_rep_set;
  end

  // Next-state logic; render_done wins over a coincident timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_timeout   = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_pending != 4'b0000) begin
          w_state_nxt = ISSUE;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ISSUE: w_state_nxt = WAIT_RENDER;
      WAIT_RENDER: begin
        if (render_done) begin
          w_state_nxt = COOLDOWN;
        end else if (r_wait_cnt == WAIT_LAST) begin
          w_state_nxt = COOLDOWN;
          w_timeout   = 1'b1;
        end else begin
          w_state_nxt = WAIT_RENDER;
        end
      end
      COOLDOWN: begin
        if (r_cool_cnt == COOL_LAST) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = COOLDOWN;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, counters, pending flags and registered outputs.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state       <= IDLE;
      r_pending     <= 4'b0000;
      r_wait_cnt    <= '0;
      r_cool_cnt    <= '0;
      r_key_pressed <= 4'b0000;
      r_refresh_req <= 1'b0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pend_nxt;
      if (r_state == WAIT_RENDER) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end else begin
        r_wait_cnt <= '0;
      end
      if (r_state == COOLDOWN) begin
        r_cool_cnt <= r_cool_cnt + 1'b1;
      end else begin
        r_cool_cnt <= '0;
      end
      if (w_state_nxt == ISSUE) begin
        r_key_pressed <= prio_onehot(r_pending);
        r_refresh_req <= 1'b1;
      end else begin
        r_key_pressed <= 4'b0000;
        r_refresh_req <= 1'b0;
      end
      r_busy        <= (w_state_nxt != IDLE);
      r_timeout_err <= w_timeout;
    end
  end

  assign key_pressed = r_key_pressed;
  assign refresh_req = r_refresh_req;
  assign busy        = r_busy;
  assign timeout_err = r_timeout_err;

endmodule
